friscv_axil_apb_bridge: RTL

- AXI4-lite slave to APB-like master bridge that drives the I/O subsystem's master port (mst_en/mst_wr/mst_addr/mst_wdata/mst_strb, mst_rdata/mst_ready).
- Sits between the core's data-memory AXI4-lite path and the I/O interconnect.
- Serialises reads and writes into one outstanding APB transfer at a time, with round-robin arbitration.
- Adds a transfer timeout that returns SLVERR when the I/O slave never answers.

---
 rtl/friscv_axil_apb_bridge.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/friscv_axil_apb_bridge.sv
// ---------------------------------------------------------------------------
// friscv_axil_apb_bridge
//   AXI4-lite slave to APB-like master bridge. Reads and writes are serialised
//   into a single outstanding master transfer. When both a read and a write are
//   pending at once, the side opposite the last served one wins. A transfer
//   that waits TIMEOUT cycles without mst_ready completes with SLVERR.
//
// Ports
//   aclk, aresetn (async, active low), srst (sync, active high)
//   aw*/w*/b*   : AXI4-lite write address, data and response channels
//   ar*/r*      : AXI4-lite read address and data channels
//   mst_*       : APB-like master port towards the I/O interconnect
//   dbg_state   : current FSM state, for observation only
//
// Handshake rule used on every channel: a transfer happens on the rising clock
// edge where valid and ready are both high. A valid, once raised, holds its
// payload until that edge. The bridge drives its ready outputs combinationally
// from the valids, and only while it is idle.
// ---------------------------------------------------------------------------
module friscv_axil_apb_bridge #(
  parameter int AXI_ADDRW = 32,
  parameter int ADDRW     = 16,
  parameter int XLEN      = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 srst,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [AXI_ADDRW-1:0] awaddr,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN/8-1:0]    wstrb,
  output logic                 bvalid,
  input  logic                 bready,
  output logic [1:0]           bresp,
  input  logic                 arvalid,
  output logic                 arready,
  input  logic [AXI_ADDRW-1:0] araddr,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [XLEN-1:0]      rdata,
  output logic [1:0]           rresp,
  output logic                 mst_en,
  output logic                 mst_wr,
  output logic [ADDRW-1:0]     mst_addr,
  output logic [XLEN-1:0]      mst_wdata,
  output logic [XLEN/8-1:0]    mst_strb,
  input  logic [XLEN-1:0]      mst_rdata,
  input  logic                 mst_ready,
  output logic [2:0]           dbg_state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] APB_WR = 3'd1;
  localparam logic [2:0] APB_RD = 3'd2;
  localparam logic [2:0] WRESP  = 3'd3;
  localparam logic [2:0] RRESP  = 3'd4;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Count value seen during the last allowed wait cycle.
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [2:0]        state;
  logic              rd_first;
  logic [ADDRW-1:0]  addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN/8-1:0] strb_q;
  logic [CW-1:0]     cnt;
  logic              wr_elig;
  logic              rd_elig;
  logic              take_wr;
  logic              take_rd;
  logic              timed_out;
  logic              unused_addr;

  assign wr_elig = awvalid & wvalid;
  assign rd_elig = arvalid;
  // Read wins a tie only when it is its turn; a lone request always wins.
  assign take_rd = (state == IDLE) & rd_elig & (rd_first | ~wr_elig);
  assign take_wr = (state == IDLE) & wr_elig & ~take_rd;

  assign awready = take_wr;
  assign wready  = take_wr;
  assign arready = take_rd;

  // mst_ready in the last allowed cycle takes precedence over the timeout.
  assign timed_out = (TIMEOUT != 0) && !mst_ready && (cnt == TO_LAST);

  assign mst_en    = (state == APB_WR) | (state == APB_RD);
  assign mst_wr    = (state == APB_WR);
  assign mst_addr  = addr_q;
  assign mst_wdata = wdata_q;
  assign mst_strb  = (state == APB_WR) ? strb_q : '0;
  assign bvalid    = (state == WRESP);
  assign rvalid    = (state == RRESP);
  assign dbg_state = state;

  assign unused_addr = ^{awaddr[AXI_ADDRW-1:ADDRW], araddr[AXI_ADDRW-1:ADDRW]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      rd_first <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      cnt      <= '0;
      bresp    <= OKAY;
      rresp    <= OKAY;
      rdata    <= '0;
    end else if (srst) begin
      state    <= IDLE;
      rd_first <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      cnt      <= '0;
      bresp    <= OKAY;
      rresp    <= OKAY;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (take_wr) begin
            addr_q   <= awaddr[ADDRW-1:0];
            wdata_q  <= wdata;
            strb_q   <= wstrb;
            rd_first <= 1'b1;
            state    <= APB_WR;
          end else if (take_rd) begin
            addr_q   <= araddr[ADDRW-1:0];
            rd_first <= 1'b0;
            state    <= APB_RD;
          end
        end
        APB_WR: begin
          if (mst_ready) begin
            bresp <= OKAY;
            state <= WRESP;
          end else if (timed_out) begin
            bresp <= SLVERR;
            state <= WRESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        APB_RD: begin
          if (mst_ready) begin
            rresp <= OKAY;
            rdata <= mst_rdata;
            state <= RRESP;
          end else if (timed_out) begin
            rresp <= SLVERR;
            rdata <= '0;
            state <= RRESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRESP: if (bready) state <= IDLE;
        RRESP: if (rready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
